// File: rtl/cp0_hilo_pkg.sv
// rtl/cp0_hilo_pkg.sv - CP0 register map, exception codes and register word packing
package cp0_hilo_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 8;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_SYS  = 5'd8
  } exc_code_e;

  function automatic logic [31:0] status_word(input logic [7:0] im, input logic exl,
                                              input logic ie);
    logic [31:0] w;
    w = '0;
    w[ST_IM_LO +: 8] = im;
    w[ST_EXL]        = exl;
    w[ST_IE]         = ie;
    return w;
  endfunction

  function automatic logic [31:0] cause_word(input logic [7:0] ip, input logic [4:0] code);
    logic [31:0] w;
    w = '0;
    w[CA_IP_LO +: 8]  = ip;
    w[CA_EXC_LO +: 5] = code;
    return w;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - free-running Count, Compare and the sticky timer interrupt (IP7)
module cp0_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_count_we,
  input  logic        i_compare_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_timer_ip
);

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_timer_ip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_compare  <= '0;
      r_timer_ip <= 1'b0;
    end else begin
      r_count <= i_count_we ? i_wdata : r_count + 32'd1;
      if (i_compare_we) begin
        r_compare <= i_wdata;
      end
      // Compare write acknowledges the interrupt and beats a same-cycle match.
      if (i_compare_we) begin
        r_timer_ip <= 1'b0;
      end else if (r_count == r_compare) begin
        r_timer_ip <= 1'b1;
      end
    end
  end

  assign o_count    = r_count;
  assign o_compare  = r_compare;
  assign o_timer_ip = r_timer_ip;

endmodule

// File: rtl/globaldefine.sv
// rtl/globaldefine.sv - shared CP0 register numbers, exception codes and bit positions
`ifndef GLOBALDEFINE_SV
`define GLOBALDEFINE_SV

`define CP0_REG_COUNT   5'd9
`define CP0_REG_COMPARE 5'd11
`define CP0_REG_STATUS  5'd12
`define CP0_REG_CAUSE   5'd13
`define CP0_REG_EPC     5'd14

`define EXC_CODE_INT    5'd0
`define EXC_CODE_ADEL   5'd4
`define EXC_CODE_SYS    5'd8

`define STATUS_IE       0
`define STATUS_EXL      1
`define STATUS_IM_LO    8
`define CAUSE_EXC_LO    2
`define CAUSE_IP_LO     8

`endif

// File: rtl/cp0_hilo.sv
// rtl/cp0_hilo.sv - CP0 Status/Cause/EPC, HI/LO, exception priority and PC redirect
module cp0_hilo
  import cp0_hilo_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mtc0,
  input  logic        mfc0,
  input  logic        mthi,
  input  logic        mfhi,
  input  logic        mtlo,
  input  logic        mflo,
  input  logic        c0_eret,
  input  logic [4:0]  reg_d,
  input  logic [31:0] rt2cp0,
  input  logic [31:0] rs2hilo,
  input  logic        add_err,
  input  logic        syscall,
  input  logic        ext_int,
  input  logic [31:0] pc,
  output logic [31:0] rdfcp0,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        exl
);

  logic        r_ie;
  logic        r_exl;
  logic [7:0]  r_im;
  logic [4:0]  r_exccode;
  logic [1:0]  r_ip_sw;
  logic [31:0] r_epc;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_sync1;
  logic        r_sync2;

  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_timer_ip;
  logic [7:0]  w_ip;
  logic        w_int_req;
  logic        w_exc_take;
  exc_code_e   w_exc_code;
  logic        w_wr_en;
  logic        w_eret;
  logic [31:0] w_status;
  logic [31:0] w_cause;

  assign w_ip      = {w_timer_ip, 4'b0000, r_sync2, r_ip_sw};
  assign w_int_req = (|(w_ip & r_im)) & r_ie & ~r_exl;
  assign w_exc_take = add_err | syscall | w_int_req;
  assign w_exc_code = add_err ? EXC_ADEL : (syscall ? EXC_SYS : EXC_INT);

  // A taken exception owns the cycle: architectural writes and eret are dropped.
  assign w_wr_en = mtc0 & ~w_exc_take;
  assign w_eret  = c0_eret & ~w_exc_take;

  assign w_status = status_word(r_im, r_exl, r_ie);
  assign w_cause  = cause_word(w_ip, r_exccode);

  cp0_timer u_timer (
    .clk          (clk),
    .rst_n        (rst),
    .i_count_we   (w_wr_en && (reg_d == REG_COUNT)),
    .i_compare_we (w_wr_en && (reg_d == REG_COMPARE)),
    .i_wdata      (rt2cp0),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_timer_ip   (w_timer_ip)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= ext_int;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ie      <= 1'b0;
      r_exl     <= 1'b0;
      r_im      <= '0;
      r_exccode <= '0;
      r_ip_sw   <= '0;
      r_epc     <= '0;
    end else if (w_exc_take) begin
      r_epc     <= pc;
      r_exccode <= w_exc_code;
      r_exl     <= 1'b1;
    end else begin
      if (w_eret) begin
        r_exl <= 1'b0;
      end
      if (w_wr_en) begin
        case (reg_d)
          REG_STATUS: begin
            r_im  <= rt2cp0[ST_IM_LO +: 8];
            r_exl <= rt2cp0[ST_EXL];
            r_ie  <= rt2cp0[ST_IE];
          end
          REG_CAUSE: r_ip_sw <= rt2cp0[CA_IP_LO +: 2];
          REG_EPC:   r_epc   <= rt2cp0;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (!w_exc_take) begin
      if (mthi) r_hi <= rs2hilo;
      if (mtlo) r_lo <= rs2hilo;
    end
  end

  always_comb begin
    rdfcp0 = '0;
    if (mfc0) begin
      case (reg_d)
        REG_COUNT:   rdfcp0 = w_count;
        REG_COMPARE: rdfcp0 = w_compare;
        REG_STATUS:  rdfcp0 = w_status;
        REG_CAUSE:   rdfcp0 = w_cause;
        REG_EPC:     rdfcp0 = r_epc;
        default:     rdfcp0 = '0;
      endcase
    end else if (mfhi) begin
      rdfcp0 = r_hi;
    end else if (mflo) begin
      rdfcp0 = r_lo;
    end
  end

  // Gated by reset so the PC mux is released the moment reset asserts.
  assign redirect    = rst & (w_exc_take | c0_eret);
  assign redirect_pc = w_exc_take ? EXC_VEC : r_epc;
  assign exl         = r_exl;

endmodule
